// File: rtl/lsl8_iter_pkg.sv
// Shared definitions for the lsl8_iter multi-cycle left shifter:
// data/shift-amount widths and the FSM state encoding.
package lsl8_iter_pkg;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/lsl8_iter_if.sv
// Request/result bundle for lsl8_iter. The rot signal exists only when
// ROTATE_EN is defined.
interface lsl8_iter_if
    import lsl8_iter_pkg::*;
();
    logic             start;
    logic [WIDTH-1:0] d_in;
    logic [SHW-1:0]   shamt;
`ifdef ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] d_out;
    logic             carry_out;
    logic             busy;
    logic             done;

    modport master (
        output start, d_in, shamt,
`ifdef ROTATE_EN
        output rot,
`endif
        input  d_out, carry_out, busy, done
    );

    modport slave (
        input  start, d_in, shamt,
`ifdef ROTATE_EN
        input  rot,
`endif
        output d_out, carry_out, busy, done
    );
endinterface

// File: rtl/lsl8_iter_step.sv
// Combinational one-bit left step. With i_rot=0 the vacated LSB is
// zero-filled; with i_rot=1 the outgoing MSB wraps into the LSB.
module lsl8_iter_step
    import lsl8_iter_pkg::*;
(
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_rot,
    output logic [WIDTH-1:0] o_q,
    output logic             o_out_bit
);

    assign o_q       = {i_d[WIDTH-2:0], i_rot & i_d[WIDTH-1]};
    assign o_out_bit = i_d[WIDTH-1];

endmodule

// File: rtl/lsl8_iter.sv
// lsl8_iter: multi-cycle logical shift-left, one bit per clock.
// Build option: define ROTATE_EN to add the rot input (rotate-left mode).
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | shifting one bit per cycle, busy=1
// ST_DONE  | result valid, done=1 for one cycle; accepts a new start
module lsl8_iter
    import lsl8_iter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    lsl8_iter_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_d_out;
    logic             r_carry_out;
    logic             w_accept;
    logic             w_last;
    logic             w_rot;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_bit;

`ifdef ROTATE_EN
    logic r_rot;
    assign w_rot = r_rot;
`else
    assign w_rot = 1'b0;
`endif

    lsl8_iter_step u_step (
        .i_d       (r_sreg),
        .i_rot     (w_rot),
        .o_q       (w_step_q),
        .o_out_bit (w_step_bit)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode; DONE re-accepts start so back-to-back ops need no bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (bus.shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, shifting, and output load on entry to DONE only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_d_out     <= '0;
            r_carry_out <= 1'b0;
`ifdef ROTATE_EN
            r_rot       <= 1'b0;
`endif
        end else if (w_accept) begin
            r_sreg <= bus.d_in;
            r_cnt  <= bus.shamt;
`ifdef ROTATE_EN
            r_rot  <= bus.rot;
`endif
            if (bus.shamt == '0) begin
                r_d_out     <= bus.d_in;
                r_carry_out <= 1'b0;
            end
        end else if (r_state == ST_SHIFT) begin
            r_sreg <= w_step_q;
            r_cnt  <= r_cnt - 1'b1;
            if (w_last) begin
                r_d_out     <= w_step_q;
                r_carry_out <= w_step_bit;
            end
        end
    end

    assign bus.d_out     = r_d_out;
    assign bus.carry_out = r_carry_out;
    assign bus.busy      = (r_state == ST_SHIFT);
    assign bus.done      = (r_state == ST_DONE);

endmodule
